// File: rtl/writeback_regfile_pkg.sv
// Shared definitions for the writeback stage: MA bundle layout
// and register-file geometry.
package writeback_regfile_pkg;

    localparam int DATA_W      = 64;
    localparam int REG_ADDR_W  = 4;

    localparam int MA_VAL_LSB  = 0;
    localparam int MA_VAL_MSB  = 63;
    localparam int MA_RD_LSB   = 64;
    localparam int MA_RD_MSB   = 67;
    localparam int MA_WE_BIT   = 68;
    localparam int MA_BUNDLE_W = 69;

    // First field lands in the MSB, so we is bit 68 and val is [63:0]
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     val;
    } ma_bundle_t;

endpackage

// File: rtl/writeback_regfile_core.sv
// Register array: one synchronous write port, two combinational
// read ports, synchronous clear.
module regfile_core
    import writeback_regfile_pkg::*;
#(
    parameter int DW   = 64,
    parameter int NR   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [DW-1:0]         i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr1,
    input  logic [REG_ADDR_W-1:0] i_raddr2,
    output logic [DW-1:0]         o_rdata1,
    output logic [DW-1:0]         o_rdata2
);

    logic [DW-1:0] r_regs [NR];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: WB pipeline register, commit into the register
// file, two bypassed read ports and a retired-write counter.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREG   = 16,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MA_BUNDLE_W-1:0] ma_bundle,
    input  logic                   flush,
    input  logic [REG_ADDR_W-1:0]  rs1_addr,
    input  logic [REG_ADDR_W-1:0]  rs2_addr,
    output logic [DATA_W-1:0]      rs1_data,
    output logic [DATA_W-1:0]      rs2_data,
    output logic                   wb_valid,
    output logic [REG_ADDR_W-1:0]  wb_rd,
    output logic [CNT_W-1:0]       retired_cnt
);

    ma_bundle_t            w_ma;
    logic                  w_commit;
    logic [DATA_W-1:0]     w_rf_rdata1;
    logic [DATA_W-1:0]     w_rf_rdata2;
    logic [DATA_W-1:0]     w_rs1_data;
    logic [DATA_W-1:0]     w_rs2_data;

    logic                  r_wb_valid;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [DATA_W-1:0]     r_wb_value;
    logic [CNT_W-1:0]      r_cnt;

    assign w_ma     = ma_bundle;
    // flush kills the held entry as well as the incoming one
    assign w_commit = r_wb_valid & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_value <= '0;
            r_cnt      <= '0;
        end else begin
            r_wb_valid <= w_ma.we & ~flush;
            r_wb_rd    <= w_ma.rd;
            r_wb_value <= w_ma.val;
            if (w_commit) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    regfile_core #(
        .DW (DATA_W),
        .NR (NREG)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_commit),
        .i_waddr  (r_wb_rd),
        .i_wdata  (r_wb_value),
        .i_raddr1 (rs1_addr),
        .i_raddr2 (rs2_addr),
        .o_rdata1 (w_rf_rdata1),
        .o_rdata2 (w_rf_rdata2)
    );

    // Youngest producer wins: MA input, then WB register, then array
    always_comb begin
        if (w_ma.we && (w_ma.rd == rs1_addr)) begin
            w_rs1_data = w_ma.val;
        end else if (r_wb_valid && (r_wb_rd == rs1_addr)) begin
            w_rs1_data = r_wb_value;
        end else begin
            w_rs1_data = w_rf_rdata1;
        end
    end

    always_comb begin
        if (w_ma.we && (w_ma.rd == rs2_addr)) begin
            w_rs2_data = w_ma.val;
        end else if (r_wb_valid && (r_wb_rd == rs2_addr)) begin
            w_rs2_data = r_wb_value;
        end else begin
            w_rs2_data = w_rf_rdata2;
        end
    end

    assign rs1_data    = w_rs1_data;
    assign rs2_data    = w_rs2_data;
    assign wb_valid    = r_wb_valid;
    assign wb_rd       = r_wb_rd;
    assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized bench for writeback_regfile against an architectural
// model: register array plus one in-flight write slot.
module tb_writeback_regfile;
    import writeback_regfile_pkg::*;

    logic                   clk;
    logic                   rst;
    logic [MA_BUNDLE_W-1:0] ma_bundle;
    logic                   flush;
    logic [3:0]             rs1_addr;
    logic [3:0]             rs2_addr;

    logic [63:0] rs1_data, rs2_data;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [15:0] retired_cnt;

    logic [63:0] s_rs1_data, s_rs2_data;
    logic        s_wb_valid;
    logic [3:0]  s_wb_rd;
    logic [3:0]  s_retired_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model
    logic [63:0] m_regs [16];
    logic        m_pv;
    logic [3:0]  m_prd;
    logic [63:0] m_pval;
    int unsigned m_cnt;

    writeback_regfile #(
        .DATA_W (64), .NREG (16), .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ma_bundle   (ma_bundle),
        .flush       (flush),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .retired_cnt (retired_cnt)
    );

    writeback_regfile #(
        .DATA_W (64), .NREG (16), .CNT_W (4)
    ) dut_w4 (
        .clk         (clk),
        .rst         (rst),
        .ma_bundle   (ma_bundle),
        .flush       (flush),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (s_rs1_data),
        .rs2_data    (s_rs2_data),
        .wb_valid    (s_wb_valid),
        .wb_rd       (s_wb_rd),
        .retired_cnt (s_retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_read(input logic we,
        input logic [3:0] rd, input logic [63:0] val,
        input logic [3:0] a);
        if (we && rd == a) return val;
        if (m_pv && m_prd == a) return m_pval;
        return m_regs[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_pv = 1'b0; m_prd = '0; m_pval = '0; m_cnt = 0;
    endtask

    // One clock: drive, check reads, clock, update model, check state
    task automatic cycle(input logic we, input logic [3:0] rd,
        input logic [63:0] val, input logic fl,
        input logic [3:0] a1, input logic [3:0] a2, input logic rs);
        ma_bundle = {we, rd, val};
        flush     = fl;
        rs1_addr  = a1;
        rs2_addr  = a2;
        rst       = rs;
        #1;
        chk("rs1_data", rs1_data, m_read(we, rd, val, a1));
        chk("rs2_data", rs2_data, m_read(we, rd, val, a2));
        chk("w4_rs1_data", s_rs1_data, m_read(we, rd, val, a1));
        @(posedge clk);
        if (rs) begin
            m_reset();
        end else begin
            if (m_pv && !fl) begin
                m_regs[m_prd] = m_pval;
                m_cnt++;
            end
            m_pv = we && !fl; m_prd = rd; m_pval = val;
        end
        #1;
        chk("wb_valid", {63'd0, wb_valid}, {63'd0, m_pv});
        chk("wb_rd", {60'd0, wb_rd}, {60'd0, m_prd});
        chk("retired_cnt", {48'd0, retired_cnt},
            {48'd0, m_cnt[15:0]});
        chk("w4_retired_cnt", {60'd0, s_retired_cnt},
            {60'd0, m_cnt[3:0]});
    endtask

    task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
        cycle(1'b0, 4'd0, 64'd0, 1'b0, a1, a2, 1'b0);
    endtask

    initial begin
        logic [63:0] rv;
        rst = 1'b1; ma_bundle = '0; flush = 1'b0;
        rs1_addr = '0; rs2_addr = '0;
        m_reset();
        @(posedge clk); #1;

        // Reset then idle
        cycle(1'b0, 4'd0, 64'd0, 1'b0, 4'd3, 4'd15, 1'b1);
        cycle(1'b0, 4'd0, 64'd0, 1'b0, 4'd3, 4'd15, 1'b1);
        idle(4'd3, 4'd15);
        chk("reset_rs1_zero", rs1_data, 64'd0);
        chk("reset_cnt_zero", {48'd0, retired_cnt}, 64'd0);

        // Basic write through MA, WB and array
        cycle(1'b1, 4'd5, 64'hDEAD_BEEF, 1'b0, 4'd5, 4'd0, 1'b0);
        idle(4'd5, 4'd5);
        chk("basic_cnt", {48'd0, retired_cnt}, 64'd1);
        idle(4'd5, 4'd1);
        chk("basic_arr", rs1_data, 64'hDEAD_BEEF);

        // Back-to-back same rd
        cycle(1'b1, 4'd7, 64'd1, 1'b0, 4'd7, 4'd7, 1'b0);
        cycle(1'b1, 4'd7, 64'd2, 1'b0, 4'd7, 4'd7, 1'b0);
        idle(4'd7, 4'd7);
        idle(4'd7, 4'd7);
        chk("b2b_final", rs1_data, 64'd2);
        chk("b2b_cnt", {48'd0, retired_cnt}, 64'd3);

        // Disabled write never bypasses or counts
        cycle(1'b0, 4'd4, 64'hFFFF, 1'b0, 4'd4, 4'd4, 1'b0);
        idle(4'd4, 4'd4);
        idle(4'd4, 4'd4);
        chk("we0_reg4", rs1_data, 64'd0);

        // Flush drops held and incoming entries
        cycle(1'b1, 4'd9, 64'h55, 1'b0, 4'd9, 4'd10, 1'b0);
        cycle(1'b1, 4'd10, 64'h66, 1'b1, 4'd9, 4'd10, 1'b0);
        idle(4'd9, 4'd10);
        chk("flush_r9", rs1_data, 64'd0);
        chk("flush_r10", rs2_data, 64'd0);
        chk("flush_cnt", {48'd0, retired_cnt}, 64'd3);

        // 17 commits on a fresh counter: 4-bit copy wraps to 1
        cycle(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 4'(i), 64'(i + 100), 1'b0, 4'(i), 4'd0, 1'b0);
        end
        idle(4'd0, 4'd1);
        chk("wrap_w4", {60'd0, s_retired_cnt}, 64'd1);
        chk("wrap_w16", {48'd0, retired_cnt}, 64'd17);

        // Reset with a write pending
        cycle(1'b1, 4'd12, 64'hABCD, 1'b0, 4'd12, 4'd0, 1'b0);
        cycle(1'b0, 4'd0, 64'd0, 1'b0, 4'd12, 4'd0, 1'b1);
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        idle(4'd12, 4'd0);
        chk("rst_r12", rs1_data, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rv = {$urandom, $urandom};
            cycle(1'($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), rv,
                  1'($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 99) == 0));
        end

        // Drain and read every register back
        idle(4'd0, 4'd0);
        idle(4'd0, 4'd0);
        for (int a = 0; a < 16; a++) begin
            idle(4'(a), 4'(15 - a));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
